uart_tx_sched: RTL and testbench

// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte

---
 rtl/uart_tx_sched_if.sv | 41 ++++
 rtl/uart_tx_sched.sv | 135 +++++++++++++
 tb/tb_uart_tx_sched.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Requester, scheduler and transmitter bundle for uart_tx_sched.
// The scheduler uses master; requesters and transmitter use slave.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 trmt;
  logic [7:0]           tx_data;
  logic                 baud_clk;
  logic                 tx_done;

  modport master (
    input  req,
    input  req_data,
    input  tx_done,
    output ack,
    output grant_id,
    output busy,
    output trmt,
    output tx_data,
    output baud_clk
  );

  modport slave (
    output req,
    output req_data,
    output tx_done,
    input  ack,
    input  grant_id,
    input  busy,
    input  trmt,
    input  tx_data,
    input  baud_clk
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ
// requesters; also generates the transmitter's baud shift strobe.
module uart_tx_sched #(
  parameter int NUM_REQ  = 4,
  parameter int BAUD_DIV = 434
) (
  input logic             clk,
  input logic             rst_n,
  uart_tx_sched_if.master bus
);
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int SW    = ID_W + 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BAUD_DIV - 1);
  localparam logic [ID_W-1:0]  ID_TOP  = ID_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_ACK
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ID_W-1:0]    r_rr;
  logic [ID_W-1:0]    r_gid;
  logic [7:0]         r_data;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_trmt;
  logic               r_baud;
  logic [NUM_REQ-1:0] r_ack;

  logic               w_found;
  logic [ID_W-1:0]    w_pick;
  logic [ID_W-1:0]    w_idx;
  logic [SW-1:0]      w_sum;
  logic [7:0]         w_byte;
  logic [ID_W-1:0]    w_rr_nxt;
  logic               w_wait;
  logic               w_wait_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // First pending request at or after the rotation pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr} + SW'(k);
      if (w_sum >= SW'(NUM_REQ)) begin
        w_sum = w_sum - SW'(NUM_REQ);
      end
      w_idx = w_sum[ID_W-1:0];
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == ID_W'(i)) begin
        w_byte = bus.req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (w_found) w_next = S_LAUNCH;
      S_LAUNCH:    w_next = S_WAIT_LOW;
      S_WAIT_LOW:  if (!bus.tx_done) w_next = S_WAIT_HIGH;
      S_WAIT_HIGH: if (bus.tx_done) w_next = S_ACK;
      S_ACK:       w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  assign w_rr_nxt = (r_gid == ID_TOP) ? '0 : r_gid + ID_W'(1);

  assign w_wait = (r_state == S_WAIT_LOW) ||
                  (r_state == S_WAIT_HIGH);

  assign w_wait_nxt = (w_next == S_WAIT_LOW) ||
                      (w_next == S_WAIT_HIGH);

  // Baud count is held at zero outside the wait states.
  assign w_cnt_nxt = !w_wait           ? '0 :
                     (r_cnt == CNT_TOP) ? '0 :
                     r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_gid   <= '0;
      r_data  <= 8'h00;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_trmt  <= 1'b0;
      r_baud  <= 1'b0;
      r_ack   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_next != S_IDLE);
      r_trmt  <= (w_next == S_LAUNCH);
      r_baud  <= w_wait_nxt && (w_cnt_nxt == CNT_TOP);
      r_ack   <= (w_next == S_ACK) ?
                 (NUM_REQ'(1) << r_gid) : '0;
      if (r_state == S_IDLE && w_found) begin
        r_gid  <= w_pick;
        r_data <= w_byte;
      end
      if (r_state == S_ACK) begin
        r_rr <= w_rr_nxt;
      end
    end
  end

  assign bus.ack      = r_ack;
  assign bus.grant_id = r_gid;
  assign bus.busy     = r_busy;
  assign bus.trmt     = r_trmt;
  assign bus.tx_data  = r_data;
  assign bus.baud_clk = r_baud;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched driving a behavioural UART transmitter,
// checked against a frame-timing reference model.
module tb_uart_tx_sched;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FR  = 10*DIV + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.NUM_REQ(N)) bus ();

  uart_tx_sched #(
    .NUM_REQ (N),
    .BAUD_DIV(DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  // Transmitter: start + 8 data LSB first + stop, one bit per strobe
  logic [9:0] sr;
  int         nb;
  logic       tx;
  assign tx = sr[0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr          <= 10'h3FF;
      nb          <= 0;
      bus.tx_done <= 1'b1;
    end else if (bus.trmt) begin
      sr          <= {1'b1, bus.tx_data, 1'b0};
      nb          <= 0;
      bus.tx_done <= 1'b0;
    end else if (bus.baud_clk && !bus.tx_done) begin
      sr <= {1'b1, sr[9:1]};
      nb <= nb + 1;
      if (nb == 9) bus.tx_done <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int scan(input logic [N-1:0] r,
                              input int rr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (rr + k) % N;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  int             m_T    = -1;
  int             m_g    = 0;
  int             m_rr   = 0;
  logic [7:0]     m_d    = 8'h00;
  bit             p_idle = 1'b0;
  logic [N-1:0]   p_req  = '0;
  logic [8*N-1:0] p_data = '0;
  logic [N-1:0]   ack_seen = '0;
  int             bcnt   = 0;
  logic [9:0]     txb    = '0;
  logic [9:0]     last_txb = '0;
  int tq[$];
  int gq[$];
  int aq[$];
  int bq[$];

  // Frame model: a grant T cycles after an idle cycle with requests,
  // strobes every DIV cycles up to 10, ack at T+FR.
  always @(negedge clk) begin : mon
    int           d;
    logic         eb;
    logic         et;
    logic         ebd;
    logic [N-1:0] ea;
    if (!rst_n) begin
      check("rst_busy", bus.busy, 0);
      check("rst_trmt", bus.trmt, 0);
      check("rst_baud", bus.baud_clk, 0);
      check("rst_ack", bus.ack, 0);
      check("rst_gid", bus.grant_id, 0);
      check("rst_txdata", bus.tx_data, 0);
      m_T    = -1;
      m_rr   = 0;
      p_idle = 1'b0;
    end else begin
      if (p_idle && p_req != '0) begin
        m_T = cyc;
        m_g = scan(p_req, m_rr);
        m_d = p_data[8*m_g +: 8];
      end
      d   = (m_T >= 0) ? cyc - m_T : -1;
      eb  = (d >= 0) && (d <= FR);
      et  = (d == 0);
      ebd = (d > 0) && (d <= 10*DIV) && (d % DIV == 0);
      ea  = (d == FR) ? (N'(1) << m_g) : '0;
      check("busy", bus.busy, eb);
      check("trmt", bus.trmt, et);
      check("baud_clk", bus.baud_clk, ebd);
      check("ack", bus.ack, ea);
      if (eb) begin
        check("grant_id", bus.grant_id, m_g);
        check("tx_data", bus.tx_data, m_d);
      end
      if (bus.trmt) begin
        tq.push_back(cyc);
        gq.push_back(int'(bus.grant_id));
        bcnt = 0;
      end
      if (bus.baud_clk) begin
        txb = {tx, txb[9:1]};
        bcnt++;
      end
      if (bus.ack != '0) begin
        aq.push_back(cyc);
        bq.push_back(bcnt);
        last_txb = txb;
        check("tx_bits", txb, {1'b1, m_d, 1'b0});
      end
      p_idle = !eb;
      if (d == FR) begin
        m_rr = (m_g + 1) % N;
        m_T  = -1;
      end
    end
    p_req    = bus.req;
    p_data   = bus.req_data;
    ack_seen = bus.ack;
  end

  logic [N-1:0] pend = '0;
  int  cool [N];
  bit  auto_en   = 1'b0;
  bit  meddle_en = 1'b0;
  int  rate      = 0;
  int  cool_max  = 0;

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_seen[i]) begin
        bus.req[i] = 1'b0;
        pend[i]    = 1'b0;
        cool[i]    = 1 + $urandom_range(0, cool_max);
      end
    end
    if (auto_en) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if (cool[i] > 0) begin
            cool[i]--;
          end else if ($urandom_range(0, 99) < rate) begin
            bus.req[i] = 1'b1;
            bus.req_data[8*i +: 8] = 8'($urandom);
            pend[i] = 1'b1;
          end
        end
      end
      if (meddle_en && m_T >= 0 && cyc - m_T == 10) begin
        case ($urandom_range(0, 3))
          0: begin
            bus.req[m_g] = 1'b0;
            bus.req_data[8*m_g +: 8] = 8'($urandom);
          end
          1: bus.req_data[8*m_g +: 8] = 8'($urandom);
          default: ;
        endcase
      end
    end
  endtask

  task automatic do_reset();
    auto_en   = 1'b0;
    meddle_en = 1'b0;
    rst_n     = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    pend         = '0;
    for (int i = 0; i < N; i++) cool[i] = 0;
    repeat (3) step();
    rst_n = 1'b1;
    tq.delete();
    gq.delete();
    aq.delete();
    bq.delete();
  endtask

  task automatic raise(input int i, input logic [7:0] b);
    bus.req[i] = 1'b1;
    bus.req_data[8*i +: 8] = b;
    pend[i] = 1'b1;
  endtask

  task automatic wait_acks(input int n, input int budget,
                           output bit ok);
    int k;
    k = 0;
    while (aq.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (aq.size() >= n);
    check("wait_ack", ok, 1);
  endtask

  task automatic wait_trmt(input int n, input int budget,
                           output bit ok);
    int k;
    k = 0;
    while (tq.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (tq.size() >= n);
    check("wait_trmt", ok, 1);
  endtask

  initial begin : main
    bit ok;
    int r;
    int t;
    int k;

    // single request, byte A5
    do_reset();
    step();
    raise(2, 8'hA5);
    r = cyc;
    wait_acks(1, 100, ok);
    if (ok) begin
      check("t1_trmt_cyc", tq[0], r + 1);
      check("t1_grant", gq[0], 2);
      check("t1_ack_cyc", aq[0], r + 43);
      check("t1_bauds", bq[0], 10);
      check("t1_serial", last_txb, 10'b1101001010);
    end
    repeat (3) step();

    // all four from reset, re-requesting
    do_reset();
    cool_max = 0;
    rate     = 100;
    for (int i = 0; i < N; i++) raise(i, 8'(8'h10 + i));
    auto_en = 1'b1;
    wait_acks(5, 300, ok);
    auto_en = 1'b0;
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        check("t2_order", gq[i], i % N);
      end
      for (int i = 0; i < 4; i++) begin
        check("t2_spacing", tq[i+1] - tq[i], 44);
      end
    end

    // rotation after serving 1
    do_reset();
    raise(1, 8'h5A);
    wait_acks(1, 100, ok);
    repeat (3) step();
    raise(0, 8'h0F);
    raise(3, 8'hF0);
    wait_acks(3, 200, ok);
    if (ok) begin
      check("t3_first", gq[1], 3);
      check("t3_second", gq[2], 0);
    end

    // drop and change data mid-frame
    do_reset();
    raise(1, 8'h3C);
    wait_trmt(1, 20, ok);
    if (ok) begin
      t = tq[0];
      while (cyc < t + 10) step();
      bus.req[1] = 1'b0;
      bus.req_data[15:8] = 8'hFF;
      wait_acks(1, 100, ok);
      if (ok) begin
        check("t4_ack_cyc", aq[0], t + 42);
        check("t4_grant", gq[0], 1);
        check("t4_serial", last_txb, {1'b1, 8'h3C, 1'b0});
      end
    end
    repeat (3) step();

    // reset mid-frame
    do_reset();
    raise(1, 8'h77);
    wait_acks(1, 100, ok);
    repeat (3) step();
    raise(3, 8'h81);
    wait_trmt(2, 20, ok);
    if (ok) begin
      t = tq[1];
      while (cyc < t + 20) step();
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_busy", bus.busy, 0);
      check("t5_trmt", bus.trmt, 0);
      check("t5_baud", bus.baud_clk, 0);
      check("t5_ack", bus.ack, 0);
      raise(0, 8'h42);
      tq.delete();
      gq.delete();
      aq.delete();
      bq.delete();
      repeat (2) step();
      rst_n = 1'b1;
      wait_acks(2, 200, ok);
      if (ok) begin
        check("t5_after_rst", gq[0], 0);
        check("t5_pending", gq[1], 3);
        check("t5_frame_len", aq[0] - tq[0], 42);
        check("t5_bauds", bq[0], 10);
      end
    end
    repeat (3) step();

    // random traffic
    do_reset();
    rate      = 15;
    cool_max  = 8;
    auto_en   = 1'b1;
    meddle_en = 1'b1;
    repeat (3000) step();
    auto_en   = 1'b0;
    meddle_en = 1'b0;
    k = 0;
    while (pend != '0 && k < 1000) begin
      step();
      k++;
    end
    check("drain", pend, 0);
    repeat (3) step();
    check("frames_seen", aq.size() > 20, 1);
    check("ack_per_trmt", aq.size(), tq.size());
    foreach (bq[i]) check("bauds_per_frame", bq[i], 10);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
